// File: rtl/pc_sequencer.sv
// Program counter and two-level return stack for the PIC16C57 core.
// Applies decoder control transfers and squashes the prefetched word after each one.
module pc_sequencer #(
  parameter int unsigned          PC_W      = 11,
  parameter logic [PC_W-1:0]      RESET_VEC = 11'h7FF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [8:0]      k,
  input  logic [1:0]      pa,
  input  logic [7:0]      pcl_wdata,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic [1:0]      depth,
  output logic            stack_ovf,
  output logic            stack_unf
);

  localparam logic [2:0] OpSkip  = 3'b001;
  localparam logic [2:0] OpGoto  = 3'b010;
  localparam logic [2:0] OpCall  = 3'b011;
  localparam logic [2:0] OpRetlw = 3'b100;
  localparam logic [2:0] OpPclwr = 3'b101;

  logic [PC_W-1:0] tos, nos;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VEC;
      flush     <= 1'b0;
      depth     <= 2'd0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      tos       <= '0;
      nos       <= '0;
    end else if (en) begin
      pc    <= pc_inc;
      flush <= 1'b0;
      // A squashed slot always behaves as INC, so transfers never chain.
      if (!flush) begin
        case (op)
          OpSkip: flush <= 1'b1;
          OpGoto: begin
            pc    <= PC_W'({pa, k});
            flush <= 1'b1;
          end
          OpCall: begin
            pc    <= PC_W'({pa, 1'b0, k[7:0]});
            flush <= 1'b1;
            nos   <= tos;
            tos   <= pc_inc;
            if (depth == 2'd2) stack_ovf <= 1'b1;
            else               depth     <= depth + 2'd1;
          end
          OpRetlw: begin
            // An empty-stack pop still returns tos; only the flag records it.
            pc    <= tos;
            flush <= 1'b1;
            tos   <= nos;
            if (depth == 2'd0) stack_unf <= 1'b1;
            else               depth     <= depth - 2'd1;
          end
          OpPclwr: begin
            pc    <= PC_W'({pa, 1'b0, pcl_wdata});
            flush <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: one record per clock, expectations hand-computed.
module tb_pc_sequencer;

  localparam logic [2:0] INC = 3'd0, SKP = 3'd1, GTO = 3'd2, CAL = 3'd3, RET = 3'd4,
                         PCW = 3'd5;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [1:0]  pa;
    logic [8:0]  k;
    logic [7:0]  wd;
    logic [10:0] e_pc;
    logic        e_flush;
    logic [1:0]  e_depth;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [8:0]  k = '0;
  logic [1:0]  pa = '0;
  logic [7:0]  pcl_wdata = '0;
  logic [10:0] pc;
  logic        flush;
  logic [1:0]  depth;
  logic        stack_ovf;
  logic        stack_unf;

  int n_run  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op        (op),
    .k         (k),
    .pa        (pa),
    .pcl_wdata (pcl_wdata),
    .pc        (pc),
    .flush     (flush),
    .depth     (depth),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic [2:0] o, logic [1:0] p, logic [8:0] kk,
                              logic [7:0] w, logic [10:0] epc, logic ef, logic [1:0] ed,
                              logic eo, logic eu);
    vec_t v;
    v.rst = r; v.en = e; v.op = o; v.pa = p; v.k = kk; v.wd = w;
    v.e_pc = epc; v.e_flush = ef; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; en = v.en; op = v.op; pa = v.pa; k = v.k; pcl_wdata = v.wd;
    @(posedge clk);
    #1;
    n_run++;
    if (pc !== v.e_pc || flush !== v.e_flush || depth !== v.e_depth ||
        stack_ovf !== v.e_ovf || stack_unf !== v.e_unf) begin
      n_fail++;
      $display("FAIL %s: got pc=%h flush=%b depth=%0d ovf=%b unf=%b, want pc=%h flush=%b depth=%0d ovf=%b unf=%b",
               name, pc, flush, depth, stack_ovf, stack_unf,
               v.e_pc, v.e_flush, v.e_depth, v.e_ovf, v.e_unf);
    end
  endtask

  initial begin
    // reset and wrap
    vecs.push_back(mk(1, 1, INC, 0, 9'h000, 8'h00, 11'h7FF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h001, 0, 0, 0, 0));
    // GOTO and squash of a CALL in the flush slot
    vecs.push_back(mk(0, 1, GTO, 0, 9'h00F, 8'h00, 11'h00F, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, GTO, 2, 9'h1A5, 8'h00, 11'h5A5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h040, 8'h00, 11'h5A6, 0, 0, 0, 0));
    // nested CALL/RETLW
    vecs.push_back(mk(0, 1, GTO, 0, 9'h0FF, 8'h00, 11'h0FF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h100, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h040, 8'h00, 11'h040, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h041, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h080, 8'h00, 11'h080, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h081, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h042, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h043, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h101, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h102, 0, 0, 0, 0));
    // SKIP and PCL write
    vecs.push_back(mk(0, 1, GTO, 0, 9'h0EF, 8'h00, 11'h0EF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h0F0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, SKP, 0, 9'h000, 8'h00, 11'h0F1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h0F2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, PCW, 3, 9'h000, 8'hFF, 11'h6FF, 1, 0, 0, 0));
    // stall while flush is pending, then stall with a GOTO presented
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, GTO, 1, 9'h0AA, 8'h00, 11'h6FF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h700, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, GTO, 1, 9'h0AA, 8'h00, 11'h700, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, GTO, 1, 9'h0AA, 8'h00, 11'h2AA, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h2AB, 0, 0, 0, 0));
    // overflow then underflow
    vecs.push_back(mk(1, 1, INC, 0, 9'h000, 8'h00, 11'h7FF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h00F, 8'h00, 11'h00F, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h010, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h01F, 8'h00, 11'h01F, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h020, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, CAL, 0, 9'h030, 8'h00, 11'h030, 1, 2, 1, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h031, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, RET, 0, 9'h000, 8'h00, 11'h031, 0, 2, 1, 0));
    vecs.push_back(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h021, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h022, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h011, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h012, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h011, 1, 0, 1, 1));
    // reset wins over a deasserted enable and clears sticky flags
    vecs.push_back(mk(1, 0, INC, 0, 9'h000, 8'h00, 11'h7FF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h000, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // reset mid-sequence with flush=1 and depth=2
    apply(mk(0, 1, CAL, 0, 9'h010, 8'h00, 11'h010, 1, 1, 0, 0), "mid_call1");
    apply(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h011, 0, 1, 0, 0), "mid_inc");
    apply(mk(0, 1, CAL, 1, 9'h120, 8'h00, 11'h220, 1, 2, 0, 0), "mid_call2");
    apply(mk(1, 1, RET, 0, 9'h000, 8'h00, 11'h7FF, 0, 0, 0, 0), "mid_rst");
    // stack entries must be back to zero after reset
    apply(mk(0, 1, INC, 0, 9'h000, 8'h00, 11'h000, 0, 0, 0, 0), "post_rst_inc");
    apply(mk(0, 1, RET, 0, 9'h000, 8'h00, 11'h000, 1, 0, 0, 1), "post_rst_pop");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the PIC16C57 core. It owns the 11-bit program counter and the two-level hardware return stack. It applies increment, skip, GOTO, CALL, RETLW and PCL-write updates from the instruction decoder, and it raises a one-cycle flush to discard the prefetched instruction after any control transfer. It sits between the decoder/STATUS register and the program-memory address port.

## Interface
- PC_W, 11, program-counter width (2K-word program space)
- RESET_VEC, 11'h7FF, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  cycle enable; low = full stall, no state changes
- op  input  3  000 INC, 001 SKIP, 010 GOTO, 011 CALL, 100 RETLW, 101 PCLWR, 110/111 treated as INC
- k  input  9  instruction literal field
- pa  input  2  STATUS page bits PA1:PA0
- pcl_wdata  input  8  ALU result for a PCL write
- pc  output  11  fetch address (registered)
- flush  output  1  current fetched instruction must execute as NOP (registered)
- depth  output  2  stack occupancy, 0..2
- stack_ovf  output  1  sticky, set by a push at depth 2
- stack_unf  output  1  sticky, set by a pop at depth 0

## Operation
- All state updates only on clk rising edge with en=1. Reset has priority over en.
- Reset values:
  - pc=RESET_VEC
  - flush=0, depth=0, stack_ovf=0, stack_unf=0
  - stack entries tos=0, nos=0
- Effective op = INC whenever flush=1. The squashed instruction's op is ignored, and flush clears.
- INC: pc <= pc+1, modulo 2^11 (7FF wraps to 000); flush <= 0.
- SKIP: pc <= pc+1; flush <= 1.
- GOTO: pc <= {pa, k[8:0]}; flush <= 1.
- CALL:
  - pc <= {pa, 1'b0, k[7:0]}; flush <= 1.
  - Push: nos <= tos, tos <= pc+1 (pc here is the current value before update).
  - depth <= min(depth+1, 2).
  - If depth was 2: old nos is lost and stack_ovf <= 1.
- RETLW:
  - pc <= tos; flush <= 1.
  - Pop: tos <= nos, nos unchanged (repeated pops return nos).
  - depth <= max(depth-1, 0).
  - If depth was 0: stack_unf <= 1, and pc still loads tos.
- PCLWR: pc <= {pa, 1'b0, pcl_wdata}; flush <= 1.
- stack_ovf and stack_unf clear only on rst.
- No arithmetic exceeds PC_W bits. pc+1 carries are discarded.

## Timing
- Single-cycle latency: op sampled at edge N, new pc visible after edge N.
- flush is asserted for exactly one enabled cycle after any transfer or SKIP. Two transfers can never be back-to-back, because the second is squashed.
- en=0 holds pc, flush, stack, depth and flags unchanged, regardless of op.
- rst asserted mid-sequence (e.g. flush=1, depth=2) returns all outputs to reset values on the next edge.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset/wrap:
  - rst for 1 cycle -> pc=7FF, flush=0, depth=0.
  - One INC -> pc=000.
  - INC again -> pc=001.
- GOTO with flush squash:
  - At pc=010, op=GOTO, pa=2, k=1A5 -> pc=5A5, flush=1.
  - Next cycle op=CALL -> ignored: pc=5A6, depth unchanged, flush=0.
- CALL/RETLW nesting:
  - At pc=100, CALL pa=0 k=40 -> pc=040, tos=101, depth=1.
  - INC, then at pc=041 CALL k=80 -> pc=080, depth=2.
  - RETLW (after flush cycle) -> pc=042.
  - RETLW -> pc=101, depth=0, no flags set.
- Overflow and underflow:
  - Three CALLs from pc=000, 010, 020 -> depth=2, stack_ovf=1.
  - Two RETLWs -> return to 021, then 011.
  - Third RETLW -> pc=011 again, stack_unf=1.
- SKIP/PCLWR:
  - At pc=0F0, SKIP -> pc=0F1, flush=1, then pc=0F2.
  - PCLWR with pa=3, pcl_wdata=FF -> pc=6FF, flush=1.
- Stall:
  - en=0 for 3 cycles with op=GOTO -> pc, flush, depth unchanged.
  - Reassert en -> GOTO takes effect on the first enabled edge.
